// File: rtl/sc_udatapath_sequencer.sv
// Micro-sequencer for the register-file/ALU datapath.
// Steps one register-transfer command through READ/EXEC/WRITE/DONE.
module sc_udatapath_sequencer #(
  parameter int NUM_REGS      = 8,
  parameter int REGADDR_WIDTH = 3,
  parameter int NUM_FIXED     = 2,
  parameter int OPCODE_WIDTH  = 4,
  parameter logic [OPCODE_WIDTH-1:0] OP_RESERVED = 4'hF,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                     SC_Seq_CLOCK_50,
  input  logic                     SC_RegFIXED_Reset_InHigh,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [REGADDR_WIDTH-1:0] cmd_srcA,
  input  logic [REGADDR_WIDTH-1:0] cmd_srcB,
  input  logic [REGADDR_WIDTH-1:0] cmd_dest,
  input  logic [OPCODE_WIDTH-1:0]  cmd_op,
  output logic [REGADDR_WIDTH-1:0] busA_sel,
  output logic [REGADDR_WIDTH-1:0] busB_sel,
  output logic [OPCODE_WIDTH-1:0]  alu_op,
  output logic [NUM_REGS-1:0]      load_en,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [COUNT_WIDTH-1:0]   cmd_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic [REGADDR_WIDTH-1:0] srcA_q, srcB_q, dest_q;
  logic [OPCODE_WIDTH-1:0]  op_q;
  logic [COUNT_WIDTH-1:0]   count_q;
  logic                     xfer;
  logic                     illegal;
  logic                     sel_on;
  logic                     op_on;

  assign cmd_ready = (state_q == S_IDLE) && !SC_RegFIXED_Reset_InHigh;
  assign xfer      = cmd_valid && cmd_ready;

  assign illegal = (32'(dest_q) < NUM_FIXED) ||
                   (32'(dest_q) >= NUM_REGS) ||
                   (op_q == OP_RESERVED);

  // State, captured command fields and completion counter
  always_ff @(posedge SC_Seq_CLOCK_50 or posedge SC_RegFIXED_Reset_InHigh) begin
    if (SC_RegFIXED_Reset_InHigh) begin
      state_q <= S_IDLE;
      srcA_q  <= '0;
      srcB_q  <= '0;
      dest_q  <= '0;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        srcA_q <= cmd_srcA;
        srcB_q <= cmd_srcB;
        dest_q <= cmd_dest;
        op_q   <= cmd_op;
      end
      if (state_q == S_WRITE) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (xfer) state_d = S_READ;
      S_READ:  state_d = illegal ? S_ERROR : S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state and captured fields
  always_comb begin
    sel_on = 1'b0;
    op_on  = 1'b0;
    unique case (1'b1)
      (state_q == S_READ):  sel_on = 1'b1;
      (state_q == S_EXEC),
      (state_q == S_WRITE): begin
        sel_on = 1'b1;
        op_on  = 1'b1;
      end
      default: ;
    endcase
  end

  // One-hot load strobe for the destination during WRITE only
  always_comb begin
    load_en = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      load_en[i] = (state_q == S_WRITE) &&
                   (32'(dest_q) == i) &&
                   (i >= NUM_FIXED);
    end
  end

  assign busA_sel  = sel_on ? srcA_q : '0;
  assign busB_sel  = sel_on ? srcB_q : '0;
  assign alu_op    = op_on ? op_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign cmd_count = count_q;

endmodule

// File: tb/tb_sc_udatapath_sequencer.sv
// Directed bench for sc_udatapath_sequencer.
// Drives and samples 1 ns after each rising edge.
module tb_sc_udatapath_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_srcA, cmd_srcB, cmd_dest;
  logic [3:0] cmd_op;
  logic [2:0] busA_sel, busB_sel;
  logic [3:0] alu_op;
  logic [7:0] load_en;
  logic       busy, done, error;
  logic [7:0] cmd_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_cnt = 8'd0;

  sc_udatapath_sequencer dut (
    .SC_Seq_CLOCK_50          (clk),
    .SC_RegFIXED_Reset_InHigh (rst),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_srcA                 (cmd_srcA),
    .cmd_srcB                 (cmd_srcB),
    .cmd_dest                 (cmd_dest),
    .cmd_op                   (cmd_op),
    .busA_sel                 (busA_sel),
    .busB_sel                 (busB_sel),
    .alu_op                   (alu_op),
    .load_en                  (load_en),
    .busy                     (busy),
    .done                     (done),
    .error                    (error),
    .cmd_count                (cmd_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [2:0] a, input logic [2:0] b,
                         input logic [3:0] op, input logic [2:0] d);
    cmd_srcA = a;
    cmd_srcB = b;
    cmd_op   = op;
    cmd_dest = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    set_cmd(3'd0, 3'd0, 4'd0, 3'd0);
    repeat (3) tick();
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready got=%0b exp=0", cmd_ready);
    end
    total++;
    if ({busy, done, error} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%b exp=000", {busy, done, error});
    end
    total++;
    if ({busA_sel, busB_sel, alu_op, load_en, cmd_count} !== 30'd0) begin
      bad++; $display("FAIL rst_outs got=%h exp=0",
                      {busA_sel, busB_sel, alu_op, load_en, cmd_count});
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rst_release_ready got=%0b exp=1", cmd_ready);
    end
  endtask

  task automatic test_legal();
    set_cmd(3'd2, 3'd3, 4'd1, 3'd4);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({busA_sel, busB_sel, alu_op, load_en} !== {3'd2, 3'd3, 4'd0, 8'd0}) begin
      bad++; $display("FAIL legal_read got=%h exp=%h",
                      {busA_sel, busB_sel, alu_op, load_en},
                      {3'd2, 3'd3, 4'd0, 8'd0});
    end
    total++;
    if ({busy, cmd_ready} !== 2'b10) begin
      bad++; $display("FAIL legal_busy got=%b exp=10", {busy, cmd_ready});
    end
    tick();
    total++;
    if ({alu_op, load_en} !== {4'd1, 8'd0}) begin
      bad++; $display("FAIL legal_exec got=%h exp=%h", {alu_op, load_en}, {4'd1, 8'd0});
    end
    tick();
    total++;
    if ({busA_sel, busB_sel, alu_op, load_en} !== {3'd2, 3'd3, 4'd1, 8'b0001_0000}) begin
      bad++; $display("FAIL legal_write got=%h exp=%h",
                      {busA_sel, busB_sel, alu_op, load_en},
                      {3'd2, 3'd3, 4'd1, 8'b0001_0000});
    end
    tick();
    exp_cnt++;
    total++;
    if ({load_en, done, error, cmd_count} !== {8'd0, 1'b1, 1'b0, exp_cnt}) begin
      bad++; $display("FAIL legal_done got=%h exp=%h",
                      {load_en, done, error, cmd_count}, {8'd0, 1'b1, 1'b0, exp_cnt});
    end
    total++;
    if ({busA_sel, busB_sel, alu_op} !== 10'd0) begin
      bad++; $display("FAIL legal_done_sel got=%h exp=0", {busA_sel, busB_sel, alu_op});
    end
    tick();
    total++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      bad++; $display("FAIL legal_idle got=%b exp=100", {cmd_ready, busy, done});
    end
  endtask

  task automatic err_case(input logic [3:0] op, input logic [2:0] d,
                          input string nm);
    logic [7:0] le_seen;
    set_cmd(3'd0, 3'd1, op, d);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    le_seen = load_en;
    tick();
    le_seen |= load_en;
    total++;
    if ({error, done, cmd_count} !== {1'b1, 1'b0, exp_cnt}) begin
      bad++; $display("FAIL %s_pulse got=%h exp=%h", nm,
                      {error, done, cmd_count}, {1'b1, 1'b0, exp_cnt});
    end
    tick();
    le_seen |= load_en;
    total++;
    if ({error, busy, cmd_ready} !== 3'b001) begin
      bad++; $display("FAIL %s_idle got=%b exp=001", nm, {error, busy, cmd_ready});
    end
    total++;
    if (le_seen !== 8'd0) begin
      bad++; $display("FAIL %s_load got=%b exp=0", nm, le_seen);
    end
  endtask

  task automatic test_error();
    err_case(4'd1, 3'd1, "err_fixed");
    err_case(4'hF, 3'd5, "err_op");
    err_case(4'd2, 3'd0, "err_r0");
  endtask

  task automatic test_back_to_back();
    logic [2:0] a [3];
    logic [2:0] d [3];
    a = '{3'd1, 3'd6, 3'd0};
    d = '{3'd2, 3'd7, 3'd3};
    cmd_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_cmd(a[c], 3'd5, 4'd3, d[c]);
      for (int k = 1; k <= 5; k++) begin
        tick();
        if (k == 1) begin
          total++;
          if (busA_sel !== a[c]) begin
            bad++; $display("FAIL b2b_sel%0d got=%0d exp=%0d", c, busA_sel, a[c]);
          end
        end
        if (k == 3) begin
          total++;
          if (load_en !== (8'd1 << d[c])) begin
            bad++; $display("FAIL b2b_load%0d got=%b exp=%b", c, load_en, 8'd1 << d[c]);
          end
        end
        if (k == 4) exp_cnt++;
        total++;
        if ({done, cmd_ready} !== {k == 4, k == 5}) begin
          bad++; $display("FAIL b2b_c%0d_k%0d got=%b exp=%b", c, k,
                          {done, cmd_ready}, {k == 4, k == 5});
        end
      end
    end
    cmd_valid = 1'b0;
    total++;
    if (cmd_count !== exp_cnt) begin
      bad++; $display("FAIL b2b_count got=%0d exp=%0d", cmd_count, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    set_cmd(3'd2, 3'd2, 4'd6, 3'd5);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    total++;
    if (load_en !== 8'b0010_0000) begin
      bad++; $display("FAIL arst_pre got=%b exp=00100000", load_en);
    end
    #2 rst = 1'b1;
    #1;
    exp_cnt = 8'd0;
    total++;
    if ({load_en, busA_sel, busB_sel, busy, cmd_ready, cmd_count} !== 24'd0) begin
      bad++; $display("FAIL arst_clear got=%h exp=0",
                      {load_en, busA_sel, busB_sel, busy, cmd_ready, cmd_count});
    end
    set_cmd(3'd7, 3'd0, 4'd2, 3'd6);
    cmd_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({busy, busA_sel} !== {1'b1, 3'd7}) begin
      bad++; $display("FAIL arst_accept got=%h exp=%h", {busy, busA_sel}, {1'b1, 3'd7});
    end
    repeat (3) tick();
    exp_cnt++;
    total++;
    if ({done, cmd_count} !== {1'b1, exp_cnt}) begin
      bad++; $display("FAIL arst_done got=%h exp=%h", {done, cmd_count}, {1'b1, exp_cnt});
    end
    tick();
  endtask

  task automatic test_wrap();
    while (exp_cnt != 8'd255) begin
      set_cmd(3'd1, 3'd2, 4'd0, 3'd3);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      repeat (4) tick();
      exp_cnt++;
    end
    total++;
    if (cmd_count !== 8'd255) begin
      bad++; $display("FAIL wrap_pre got=%0d exp=255", cmd_count);
    end
    set_cmd(3'd4, 3'd4, 4'd5, 3'd4);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    exp_cnt++;
    total++;
    if ({done, cmd_count} !== {1'b1, 8'd0}) begin
      bad++; $display("FAIL wrap got=%h exp=100", {done, cmd_count});
    end
    tick();
  endtask

  task automatic test_random();
    int xfers = 0;
    int dn = 0;
    int er = 0;
    int viol = 0;
    logic [7:0] base;
    base = exp_cnt;
    for (int i = 0; i < 1006; i++) begin
      cmd_valid = (i < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      set_cmd(3'($urandom), 3'($urandom), 4'($urandom), 3'($urandom));
      if (cmd_valid && cmd_ready) xfers++;
      tick();
      if (done) dn++;
      if (error) er++;
      if (!$onehot0(load_en)) viol++;
      if (load_en[1:0] !== 2'b00) viol++;
      if (done && error) viol++;
      if (cmd_count !== 8'(base + 8'(dn))) viol++;
    end
    exp_cnt = 8'(base + 8'(dn));
    total++;
    if (viol !== 0) begin
      bad++; $display("FAIL rand_invariants got=%0d exp=0", viol);
    end
    total++;
    if (dn + er !== xfers) begin
      bad++; $display("FAIL rand_xfers got=%0d exp=%0d", dn + er, xfers);
    end
    total++;
    if ((dn == 0) || (er == 0)) begin
      bad++; $display("FAIL rand_mix got=%0d/%0d exp=nonzero", dn, er);
    end
    total++;
    if (cmd_count !== exp_cnt) begin
      bad++; $display("FAIL rand_count got=%0d exp=%0d", cmd_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_error();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
